// File: rtl/alu_sweep_checker_if.sv
// Drive/result bus between the sweep checker and the 4-bit ALU under test.
// The checker is the master: it drives operands/opcode and receives the result.
interface alu_sweep_checker_if;
  logic [3:0] drv_A;
  logic [3:0] drv_B;
  logic [1:0] drv_op;
  logic [3:0] dut_result;

  modport master (
    output drv_A,
    output drv_B,
    output drv_op,
    input  dut_result
  );

  modport slave (
    input  drv_A,
    input  drv_B,
    input  drv_op,
    output dut_result
  );
endinterface

// File: rtl/alu_sweep_checker.sv
// Exhaustive sweep of all 1024 operand/opcode vectors for a 4-bit ALU, with a
// golden-model compare, mismatch counter, first-failure capture and sticky flag.
module alu_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  alu_sweep_checker_if.master bus,
  output logic                busy,
  output logic                done,
  output logic [10:0]         mismatch_count,
  output logic                trojan_flag,
  output logic [3:0]          ff_A,
  output logic [3:0]          ff_B,
  output logic [1:0]          ff_op,
  output logic [3:0]          ff_observed,
  output logic [3:0]          ff_expected
);

  typedef enum logic [1:0] {StIdle, StApply, StCheck, StDone} state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [9:0]  idx_q, idx_d;
  logic [3:0]  settle_q, settle_d;
  logic [10:0] mm_cnt_q, mm_cnt_d;
  logic        flag_q, flag_d;
  logic [3:0]  ff_a_q, ff_a_d;
  logic [3:0]  ff_b_q, ff_b_d;
  logic [1:0]  ff_op_q, ff_op_d;
  logic [3:0]  ff_obs_q, ff_obs_d;
  logic [3:0]  ff_exp_q, ff_exp_d;
  logic [3:0]  ref_result;

  // Drive outputs come straight from the registered index, so they are glitch-free.
  assign bus.drv_op = idx_q[9:8];
  assign bus.drv_A  = idx_q[7:4];
  assign bus.drv_B  = idx_q[3:0];

  always_comb begin
    ref_result = 4'd0;
    unique case (idx_q[9:8])
      2'b00: ref_result = idx_q[7:4] + idx_q[3:0];
      2'b01: ref_result = idx_q[7:4] - idx_q[3:0];
      2'b10: ref_result = idx_q[7:4] & idx_q[3:0];
      2'b11: ref_result = idx_q[7:4] | idx_q[3:0];
      default: ref_result = 4'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    mm_cnt_d = mm_cnt_q;
    flag_d   = flag_q;
    ff_a_d   = ff_a_q;
    ff_b_d   = ff_b_q;
    ff_op_d  = ff_op_q;
    ff_obs_d = ff_obs_q;
    ff_exp_d = ff_exp_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StApply;
          idx_d    = 10'd0;
          settle_d = 4'd0;
          mm_cnt_d = 11'd0;
          flag_d   = 1'b0;
          ff_a_d   = 4'd0;
          ff_b_d   = 4'd0;
          ff_op_d  = 2'd0;
          ff_obs_d = 4'd0;
          ff_exp_d = 4'd0;
        end
      end
      StApply: begin
        if (settle_q == SettleLast) begin
          settle_d = 4'd0;
          state_d  = StCheck;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      StCheck: begin
        if (bus.dut_result != ref_result) begin
          mm_cnt_d = mm_cnt_q + 11'd1;
          if (!flag_q) begin
            flag_d   = 1'b1;
            ff_a_d   = idx_q[7:4];
            ff_b_d   = idx_q[3:0];
            ff_op_d  = idx_q[9:8];
            ff_obs_d = bus.dut_result;
            ff_exp_d = ref_result;
          end
        end
        if (idx_q == 10'd1023) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 10'd1;
          state_d = StApply;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= 10'd0;
      settle_q <= 4'd0;
      mm_cnt_q <= 11'd0;
      flag_q   <= 1'b0;
      ff_a_q   <= 4'd0;
      ff_b_q   <= 4'd0;
      ff_op_q  <= 2'd0;
      ff_obs_q <= 4'd0;
      ff_exp_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      mm_cnt_q <= mm_cnt_d;
      flag_q   <= flag_d;
      ff_a_q   <= ff_a_d;
      ff_b_q   <= ff_b_d;
      ff_op_q  <= ff_op_d;
      ff_obs_q <= ff_obs_d;
      ff_exp_q <= ff_exp_d;
    end
  end

  assign busy           = (state_q == StApply) || (state_q == StCheck);
  assign done           = (state_q == StDone);
  assign mismatch_count = mm_cnt_q;
  assign trojan_flag    = flag_q;
  assign ff_A           = ff_a_q;
  assign ff_B           = ff_b_q;
  assign ff_op          = ff_op_q;
  assign ff_observed    = ff_obs_q;
  assign ff_expected    = ff_exp_q;

endmodule

// File: tb/tb_alu_sweep_checker.sv
// Bench for alu_sweep_checker: a behavioural ALU (correct / trojan / stuck-at-zero)
// sits on the slave side; sweep results are checked through an expectation queue.
module tb_alu_sweep_checker;

  localparam int ModeGood   = 0;
  localparam int ModeTrojan = 1;
  localparam int ModeStuck  = 2;

  typedef struct {
    int cycles;
    int count;
    int flag;
    int ff_a;
    int ff_b;
    int ff_op;
    int ff_obs;
    int ff_exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, trojan_flag;
  logic [10:0] mismatch_count;
  logic [3:0]  ff_A, ff_B, ff_observed, ff_expected;
  logic [1:0]  ff_op;
  int          alu_mode = ModeGood;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  logic        done_prev = 1'b0;
  exp_t        sb_q[$];

  alu_sweep_checker_if bus();

  alu_sweep_checker #(.SETTLE_CYCLES(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .bus            (bus),
    .busy           (busy),
    .done           (done),
    .mismatch_count (mismatch_count),
    .trojan_flag    (trojan_flag),
    .ff_A           (ff_A),
    .ff_B           (ff_B),
    .ff_op          (ff_op),
    .ff_observed    (ff_observed),
    .ff_expected    (ff_expected)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] alu_model(input logic [1:0] op, input logic [3:0] a,
                                           input logic [3:0] b, input int mode);
    logic [3:0] r;
    case (op)
      2'b00:   r = a + b;
      2'b01:   r = a - b;
      2'b10:   r = a & b;
      default: r = a | b;
    endcase
    if (mode == ModeTrojan && op == 2'b01 && a == 4'd15) r = a;
    if (mode == ModeStuck) r = 4'd0;
    return r;
  endfunction

  assign bus.dut_result = alu_model(bus.drv_op, bus.drv_A, bus.drv_B, alu_mode);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_count"}, 32'(mismatch_count), 0);
    chk({tag, "_flag"}, 32'(trojan_flag), 0);
    chk({tag, "_ff"}, {14'd0, ff_A, ff_B, ff_op, ff_observed, ff_expected}, 0);
    chk({tag, "_drv"}, {22'd0, bus.drv_op, bus.drv_A, bus.drv_B}, 0);
  endtask

  // Monitor: each rising done retires one expected sweep result.
  always @(negedge clk) begin
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1, expected no sweep pending");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sweep_cycles", cyc - start_cyc, e.cycles);
        chk("mismatch_count", 32'(mismatch_count), e.count);
        chk("trojan_flag", 32'(trojan_flag), e.flag);
        chk("ff_A", 32'(ff_A), e.ff_a);
        chk("ff_B", 32'(ff_B), e.ff_b);
        chk("ff_op", 32'(ff_op), e.ff_op);
        chk("ff_observed", 32'(ff_observed), e.ff_obs);
        chk("ff_expected", 32'(ff_expected), e.ff_exp);
        chk("busy_at_done", 32'(busy), 0);
        chk("drv_last", {22'd0, bus.drv_op, bus.drv_A, bus.drv_B}, 32'h3ff);
      end
    end
    done_prev <= done;
  end

  task automatic begin_sweep(input int mode);
    @(negedge clk);
    alu_mode = mode;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
    chk("busy_after_start", 32'(busy), 1);
    chk("cleared_after_start",
        {10'd0, mismatch_count, trojan_flag, ff_A, ff_B, ff_op}, 0);
    chk("drv_after_start", {22'd0, bus.drv_op, bus.drv_A, bus.drv_B}, 0);
  endtask

  task automatic run_sweep(input int mode, input bit mid_start, input exp_t e);
    bit seen;
    sb_q.push_back(e);
    begin_sweep(mode);
    if (mid_start) begin
      repeat (499) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < 2300 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL sweep_timeout: got done=0, expected done within 2048 cycles");
      sb_q.delete();
    end
  endtask

  initial begin
    exp_t e;
    bit   hit;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk_all_zero("idle_hold");

    e = '{cycles: 2048, count: 0, flag: 0, ff_a: 0, ff_b: 0, ff_op: 0, ff_obs: 0, ff_exp: 0};
    run_sweep(ModeGood, 1'b0, e);

    e = '{cycles: 2048, count: 15, flag: 1, ff_a: 15, ff_b: 1, ff_op: 1, ff_obs: 15,
          ff_exp: 14};
    run_sweep(ModeTrojan, 1'b0, e);

    // Restart from DONE with a correct ALU: previous failures must be cleared.
    e = '{cycles: 2048, count: 0, flag: 0, ff_a: 0, ff_b: 0, ff_op: 0, ff_obs: 0, ff_exp: 0};
    run_sweep(ModeGood, 1'b0, e);

    e = '{cycles: 2048, count: 910, flag: 1, ff_a: 0, ff_b: 1, ff_op: 0, ff_obs: 0, ff_exp: 1};
    run_sweep(ModeStuck, 1'b0, e);

    // Reset while vector 100 (op 0, A 6, B 4) is being applied.
    begin_sweep(ModeStuck);
    hit = 1'b0;
    for (int k = 0; k < 400 && !hit; k++) begin
      @(negedge clk);
      #1;
      if (bus.drv_op == 2'd0 && bus.drv_A == 4'd6 && bus.drv_B == 4'd4) hit = 1'b1;
    end
    chk("reached_vector_100", 32'(hit), 1);
    chk("mid_sweep_flag", 32'(trojan_flag), 1);
    rst = 1'b1;
    #1 chk_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;

    e = '{cycles: 2048, count: 910, flag: 1, ff_a: 0, ff_b: 1, ff_op: 0, ff_obs: 0, ff_exp: 1};
    run_sweep(ModeStuck, 1'b0, e);

    // start pulsed at cycle 500 of a sweep must not restart it.
    e = '{cycles: 2048, count: 0, flag: 0, ff_a: 0, ff_b: 0, ff_op: 0, ff_obs: 0, ff_exp: 0};
    run_sweep(ModeGood, 1'b1, e);

    repeat (3) @(negedge clk);
    chk("done_stable", 32'(done), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
